// File: rtl/pmu_seq.sv
// pmu_seq: tag power-management sequencer, INIT -> REC -> NUM_STG guarded stages, plus div_en/ie_en arbitration.
// Optional per-stage watchdog abort is built when PMU_SEQ_WDT_EN is defined.
module pmu_seq #(
    parameter int         NUM_STG   = 2,
    parameter int         GAP_CYC   = 3,
    parameter int         IGAP_CYC  = 4,
    parameter int         TMO_CYC   = 1024,
    parameter int         TMO_W     = 11,
    parameter logic [7:0] SORT_CODE = 8'h01
) (
    input  logic               DOUB_BLF,
    input  logic               rst,
    input  logic               tag_status,
    input  logic               init_done,
    input  logic               parse_done,
    input  logic               parse_err,
    input  logic               parse_iereq,
    input  logic [7:0]         cmd_head,
    input  logic               dec_done,
    input  logic               job_done,
    input  logic               new_cmd,
    input  logic               T2_overstep,
    input  logic [NUM_STG-1:0] stg_done,
    input  logic [NUM_STG-1:0] stg_iereq,
    output logic               init_en,
    output logic               dec_en,
    output logic [NUM_STG-1:0] stg_en,
    output logic               div_en,
    output logic               ie_en,
    output logic               tmo_err
);
    localparam int IDX_W = (NUM_STG > 1) ? $clog2(NUM_STG) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_REC,
        S_GAP,
        S_STG,
        S_END
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   stg_idx;
    logic [3:0]         gap_cnt;
    logic               init_seen;
    logic               timeout;
    logic               cur_done;
    logic               last_stg;
    logic [NUM_STG-1:0] stg_sel;
    logic               init_cut;
    logic               div_clr;
    logic               div_set;
    logic               ie_set;
    logic               ie_clr;

    if (NUM_STG < 1 || NUM_STG > 8 || GAP_CYC < 0 || GAP_CYC > 15 ||
        IGAP_CYC < 0 || IGAP_CYC > 15 || TMO_CYC < 1 || TMO_CYC >= (1 << TMO_W)) begin : g_bad_param
        $error("pmu_seq: parameter out of range");
    end

    assign cur_done = stg_done[stg_idx];
    assign last_stg = (stg_idx == IDX_W'(NUM_STG - 1));
    assign stg_sel  = NUM_STG'(1) << stg_idx;

    // Sequencer; enables are a registered decode of the current state.
    always_ff @(posedge DOUB_BLF) begin
        if (rst) begin
            state   <= S_IDLE;
            stg_idx <= '0;
            gap_cnt <= '0;
            init_en <= 1'b0;
            dec_en  <= 1'b0;
            stg_en  <= '0;
        end else begin
            init_en <= (state == S_INIT);
            dec_en  <= (state == S_REC);
            stg_en  <= (state == S_STG) ? stg_sel : '0;
            if (tag_status) begin
                state <= S_END;
            end else begin
                case (state)
                    S_IDLE: state <= S_INIT;
                    S_INIT: if (init_done) state <= S_REC;
                    S_REC: begin
                        if (parse_done && cmd_head != SORT_CODE) begin
                            state   <= S_GAP;
                            stg_idx <= '0;
                            gap_cnt <= 4'(GAP_CYC);
                        end else if (parse_err) begin
                            state <= S_REC;
                        end
                    end
                    S_GAP: begin
                        if (new_cmd) begin
                            state   <= S_REC;
                            stg_idx <= '0;
                        end else if (gap_cnt == 4'd0) begin
                            state <= S_STG;
                        end else begin
                            gap_cnt <= gap_cnt - 4'd1;
                        end
                    end
                    S_STG: begin
                        if (new_cmd) begin
                            state   <= S_REC;
                            stg_idx <= '0;
                        end else if (cur_done) begin
                            if (last_stg) begin
                                state   <= S_REC;
                                stg_idx <= '0;
                            end else begin
                                state   <= S_GAP;
                                stg_idx <= stg_idx + IDX_W'(1);
                                gap_cnt <= 4'(IGAP_CYC);
                            end
                        end else if (timeout) begin
                            state   <= S_REC;
                            stg_idx <= '0;
                        end
                    end
                    S_END:   state <= S_END;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef PMU_SEQ_WDT_EN
    logic [TMO_W-1:0] wdt;

    // A done arriving in the timeout cycle wins, as do kill and new-command aborts.
    assign timeout = (state == S_STG) && !tag_status && !new_cmd && !cur_done &&
                     (wdt == TMO_W'(TMO_CYC - 1));

    always_ff @(posedge DOUB_BLF) begin
        if (rst) begin
            wdt     <= '0;
            tmo_err <= 1'b0;
        end else begin
            tmo_err <= timeout;
            if (state != S_STG)
                wdt <= '0;
            else if (wdt != {TMO_W{1'b1}})
                wdt <= wdt + TMO_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
    assign tmo_err = 1'b0;
`endif

    // The init cut acts through the div_en register, one cycle after dec_en rises.
    assign init_cut = init_seen & dec_en;
    assign div_clr  = new_cmd | T2_overstep | init_cut;
    assign div_set  = parse_iereq | dec_done;
    assign ie_set   = parse_iereq | (|stg_iereq);
    assign ie_clr   = dec_done | stg_done[NUM_STG-1] | (job_done & (state == S_REC)) |
                      init_done | timeout;

    always_ff @(posedge DOUB_BLF) begin
        if (rst) begin
            init_seen <= 1'b0;
            div_en    <= 1'b1;
            ie_en     <= 1'b1;
        end else begin
            if (new_cmd)
                init_seen <= 1'b0;
            else if (init_done)
                init_seen <= 1'b1;

            if (div_clr)
                div_en <= 1'b0;
            else if (div_set)
                div_en <= 1'b1;

            if (ie_set)
                ie_en <= 1'b1;
            else if (ie_clr)
                ie_en <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pmu_seq.sv
// Bench for pmu_seq: directed vector table, hand-built corner sequences, then random traffic against a cycle model.
module tb_pmu_seq;
    localparam int NS   = 2;
    localparam int GAP  = 3;
    localparam int IGAP = 4;
    localparam int TMO  = 16;
    localparam int TW   = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tag_status = 1'b0;
    logic          init_done = 1'b0;
    logic          parse_done = 1'b0;
    logic          parse_err = 1'b0;
    logic          parse_iereq = 1'b0;
    logic [7:0]    cmd_head = 8'h00;
    logic          dec_done = 1'b0;
    logic          job_done = 1'b0;
    logic          new_cmd = 1'b0;
    logic          T2_overstep = 1'b0;
    logic [NS-1:0] stg_done = '0;
    logic [NS-1:0] stg_iereq = '0;
    logic          init_en;
    logic          dec_en;
    logic [NS-1:0] stg_en;
    logic          div_en;
    logic          ie_en;
    logic          tmo_err;

    always #5 clk = ~clk;

    pmu_seq #(
        .NUM_STG(NS), .GAP_CYC(GAP), .IGAP_CYC(IGAP),
        .TMO_CYC(TMO), .TMO_W(TW), .SORT_CODE(8'h01)
    ) dut (
        .DOUB_BLF(clk), .rst(rst), .tag_status(tag_status), .init_done(init_done),
        .parse_done(parse_done), .parse_err(parse_err), .parse_iereq(parse_iereq),
        .cmd_head(cmd_head), .dec_done(dec_done), .job_done(job_done), .new_cmd(new_cmd),
        .T2_overstep(T2_overstep), .stg_done(stg_done), .stg_iereq(stg_iereq),
        .init_en(init_en), .dec_en(dec_en), .stg_en(stg_en), .div_en(div_en),
        .ie_en(ie_en), .tmo_err(tmo_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase of the sequence plus elapsed-time bookkeeping.
    localparam int P_IDLE = 0, P_INIT = 1, P_REC = 2, P_GAP = 3, P_STG = 4, P_END = 5;
    int            ph = P_IDLE;
    int            gap_left = 0;
    int            stage = 0;
    int            in_stg = 0;
    bit            seen = 1'b0;
    bit            e_init, e_dec, e_div, e_ie, e_tmo;
    logic [NS-1:0] e_stg;

    task automatic model_tick();
        bit to;
        bit done_now;
        if (rst) begin
            ph = P_IDLE; gap_left = 0; stage = 0; in_stg = 0; seen = 1'b0;
            e_init = 1'b0; e_dec = 1'b0; e_stg = '0; e_div = 1'b1; e_ie = 1'b1; e_tmo = 1'b0;
            return;
        end
        done_now = stg_done[stage];
        to = 1'b0;
`ifdef PMU_SEQ_WDT_EN
        to = (ph == P_STG) && !tag_status && !new_cmd && !done_now && (in_stg + 1 == TMO);
`endif
        if (new_cmd || T2_overstep || (seen && e_dec)) e_div = 1'b0;
        else if (parse_iereq || dec_done)              e_div = 1'b1;
        if (parse_iereq || (|stg_iereq)) e_ie = 1'b1;
        else if (dec_done || stg_done[NS-1] || (job_done && ph == P_REC) || init_done || to) e_ie = 1'b0;
        if (new_cmd)        seen = 1'b0;
        else if (init_done) seen = 1'b1;
        e_init = (ph == P_INIT);
        e_dec  = (ph == P_REC);
        e_stg  = '0;
        if (ph == P_STG) e_stg[stage] = 1'b1;
        e_tmo  = to;
        if (ph == P_STG) in_stg = (in_stg + 1 > (1 << TW) - 1) ? (1 << TW) - 1 : in_stg + 1;
        else             in_stg = 0;
        if (tag_status) ph = P_END;
        else if (ph == P_IDLE) ph = P_INIT;
        else if (ph == P_INIT) begin
            if (init_done) ph = P_REC;
        end else if (ph == P_REC) begin
            if (parse_done && cmd_head != 8'h01) begin ph = P_GAP; stage = 0; gap_left = GAP; end
        end else if (ph == P_GAP) begin
            if (new_cmd) begin ph = P_REC; stage = 0; end
            else if (gap_left == 0) ph = P_STG;
            else gap_left--;
        end else if (ph == P_STG) begin
            if (new_cmd) begin ph = P_REC; stage = 0; end
            else if (done_now) begin
                if (stage == NS - 1) begin ph = P_REC; stage = 0; end
                else begin stage++; ph = P_GAP; gap_left = IGAP; end
            end else if (to) begin ph = P_REC; stage = 0; end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic clear_in();
        tag_status = 1'b0; init_done = 1'b0; parse_done = 1'b0; parse_err = 1'b0;
        parse_iereq = 1'b0; cmd_head = 8'h00; dec_done = 1'b0; job_done = 1'b0;
        new_cmd = 1'b0; T2_overstep = 1'b0; stg_done = '0; stg_iereq = '0;
    endtask

    task automatic wait_stg(input logic [NS-1:0] t, input string nm);
        int n = 0;
        while (stg_en !== t && n < 40) begin
            step();
            n++;
        end
        chk(nm, stg_en, t);
    endtask

    typedef struct {
        bit         r;
        bit         ini;
        bit         pd;
        logic [7:0] hd;
        logic [1:0] sd;
        bit         pie;
        logic [6:0] exp;   // {init_en, dec_en, stg_en[1:0], div_en, ie_en, tmo_err}
    } vec_t;

    vec_t tbl[26];
    int   drop;
    int   tm;
    int   k;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 7'b0000110};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 7'b0000110};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 7'b1000110};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 7'b1000110};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 7'b1000110};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 7'b1000100};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 7'b0100100};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 7'b0100000};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h01, 2'b00, 1'b0, 7'b0100000};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h10, 2'b00, 1'b0, 7'b0100000};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 7'b0000000};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 7'b0000000};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 7'b0000000};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 7'b0000000};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 7'b0001000};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b10, 1'b0, 7'b0001000};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b01, 1'b0, 7'b0001000};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 7'b0000000};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 7'b0000000};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 7'b0000000};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 7'b0000000};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 7'b0000110};
        tbl[22] = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 7'b0010110};
        tbl[23] = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b10, 1'b0, 7'b0010100};
        tbl[24] = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 7'b0100100};
        tbl[25] = '{1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 7'b0100000};

        for (int i = 0; i < 26; i++) begin
            rst = tbl[i].r; init_done = tbl[i].ini; parse_done = tbl[i].pd;
            cmd_head = tbl[i].hd; stg_done = tbl[i].sd; parse_iereq = tbl[i].pie;
            step();
            chk($sformatf("vec%0d", i), {init_en, dec_en, stg_en, div_en, ie_en, tmo_err}, tbl[i].exp);
        end
        clear_in();

        // New command while stage 1 is running.
        parse_done = 1'b1; cmd_head = 8'h10; step(); clear_in();
        wait_stg(2'b01, "a_stg0");
        stg_done = 2'b01; step(); clear_in();
        wait_stg(2'b10, "a_stg1");
        parse_iereq = 1'b1; step(); clear_in();
        chk("a_div_set", div_en, 1);
        new_cmd = 1'b1; step(); clear_in();
        chk("a_div_nc", div_en, 0);
        chk("a_stg_hold", stg_en, 2'b10);
        step();
        chk("a_stg_off", stg_en, 2'b00);
        chk("a_dec_on", dec_en, 1);

        // New command coincident with stage 0 done returns to REC, not GAP.
        parse_done = 1'b1; cmd_head = 8'h10; step(); clear_in();
        wait_stg(2'b01, "b_stg0");
        stg_done = 2'b01; new_cmd = 1'b1; step(); clear_in();
        step();
        chk("b_dec", dec_en, 1);
        repeat (6) step();
        chk("b_stay", {dec_en, stg_en}, 3'b100);
        parse_err = 1'b1; step(); clear_in(); step();
        chk("b_perr", {dec_en, stg_en}, 3'b100);

        // Stage done withheld.
        parse_done = 1'b1; cmd_head = 8'h10; step(); clear_in();
        wait_stg(2'b01, "c_stg0");
        parse_iereq = 1'b1; step(); clear_in();
`ifdef PMU_SEQ_WDT_EN
        k = 1;
        while (tmo_err !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        chk("c_tmo_at", k, TMO - 1);
        chk("c_ie_clr", ie_en, 0);
        chk("c_stg_still", stg_en, 2'b01);
        step();
        chk("c_tmo_pulse", tmo_err, 0);
        chk("c_dec", dec_en, 1);
        chk("c_stg_off", stg_en, 2'b00);
`else
        drop = 0;
        tm = 0;
        repeat (1100) begin
            step();
            if (stg_en !== 2'b01) drop++;
            if (tmo_err !== 1'b0) tm++;
        end
        chk("c_hold_drop", drop, 0);
        chk("c_no_tmo", tm, 0);
        chk("c_ie_kept", ie_en, 1);
`endif

        // Kill while in a stage.
        if (stg_en !== 2'b01) begin
            parse_done = 1'b1; cmd_head = 8'h10; step(); clear_in();
            wait_stg(2'b01, "d_stg0");
        end
        tag_status = 1'b1; step(); clear_in();
        step();
        chk("d_off", {init_en, dec_en, stg_en}, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            init_done = 1'b1; parse_done = 1'b1; cmd_head = 8'h10; step(); clear_in();
            step();
        end
        repeat (8) step();
        chk("d_end_hold", {init_en, dec_en, stg_en}, 4'b0000);
        rst = 1'b1; step(); rst = 1'b0;
        chk("d_rst", {init_en, dec_en, stg_en, div_en, ie_en, tmo_err}, 7'b0000110);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst         = (c % 400 == 399);
            tag_status  = ($urandom_range(0, 399) == 0);
            init_done   = ($urandom_range(0, 7) == 0);
            parse_done  = ($urandom_range(0, 5) == 0);
            cmd_head    = ($urandom_range(0, 2) == 0) ? 8'h01 : 8'($urandom_range(0, 255));
            parse_err   = ($urandom_range(0, 9) == 0);
            parse_iereq = ($urandom_range(0, 9) == 0);
            dec_done    = ($urandom_range(0, 9) == 0);
            job_done    = ($urandom_range(0, 7) == 0);
            new_cmd     = ($urandom_range(0, 39) == 0);
            T2_overstep = ($urandom_range(0, 19) == 0);
            stg_done    = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
            stg_iereq   = {($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0)};
            step();
            chk("rnd", {init_en, dec_en, stg_en, div_en, ie_en, tmo_err},
                {e_init, e_dec, e_stg, e_div, e_ie, e_tmo});
        end
        clear_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
